// File: rtl/traffic_ctrl.sv
// Toy-track traffic light sequencer: red -> green -> yellow timed by a tick
// strobe, with a blinking-yellow fault mode and a lights-off idle state.
module traffic_ctrl #(
   parameter int RED_T    = 6,
   parameter int GREEN_T  = 8,
   parameter int YELLOW_T = 2,
   parameter int CW       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       run,
   input  logic       fault,
   output logic [1:0] code,
   output logic       phase_start
);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_RED     = 3'd1,
      S_GREEN   = 3'd2,
      S_YELLOW  = 3'd3,
      S_BLK_ON  = 3'd4,
      S_BLK_OFF = 3'd5
   } state_t;

   localparam logic [1:0] CODE_RED    = 2'b00;
   localparam logic [1:0] CODE_YELLOW = 2'b01;
   localparam logic [1:0] CODE_GREEN  = 2'b10;
   localparam logic [1:0] CODE_DARK   = 2'b11;

   localparam logic [CW-1:0] RED_LAST    = CW'(RED_T - 1);
   localparam logic [CW-1:0] GREEN_LAST  = CW'(GREEN_T - 1);
   localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    code_q, code_d;
   logic          phase_start_q, phase_start_d;

   function automatic logic [1:0] code_of(input state_t s);
      logic [1:0] c;
      case (s)
         S_OFF:     c = CODE_DARK;
         S_RED:     c = CODE_RED;
         S_GREEN:   c = CODE_GREEN;
         S_YELLOW:  c = CODE_YELLOW;
         S_BLK_ON:  c = CODE_YELLOW;
         S_BLK_OFF: c = CODE_DARK;
         default:   c = CODE_DARK;
      endcase
      return c;
   endfunction

   // Next-state and counter logic; priority is fault, then run, then tick timing.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_OFF: begin
            cnt_d = CNT_ZERO;
            if (fault) begin
               state_d = S_BLK_ON;
            end else if (run) begin
               state_d = S_RED;
            end else begin
               state_d = S_OFF;
            end
         end
         S_RED, S_GREEN, S_YELLOW: begin
            if (fault) begin
               state_d = S_BLK_ON;
               cnt_d   = CNT_ZERO;
            end else if (!run) begin
               state_d = S_OFF;
               cnt_d   = CNT_ZERO;
            end else if (tick) begin
               if (state_q == S_RED && cnt_q == RED_LAST) begin
                  state_d = S_GREEN;
                  cnt_d   = CNT_ZERO;
               end else if (state_q == S_GREEN && cnt_q == GREEN_LAST) begin
                  state_d = S_YELLOW;
                  cnt_d   = CNT_ZERO;
               end else if (state_q == S_YELLOW && cnt_q == YELLOW_LAST) begin
                  state_d = S_RED;
                  cnt_d   = CNT_ZERO;
               end else begin
                  cnt_d = cnt_q + CW'(1'b1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_BLK_ON, S_BLK_OFF: begin
            cnt_d = CNT_ZERO;
            if (fault) begin
               if (tick) begin
                  state_d = (state_q == S_BLK_ON) ? S_BLK_OFF : S_BLK_ON;
               end else begin
                  state_d = state_q;
               end
            end else if (run) begin
               // Leaving blink always restarts the sequence at red.
               state_d = S_RED;
            end else begin
               state_d = S_OFF;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output registers are loaded from the next state so they track state_q exactly.
   always_comb begin
      code_d        = code_of(state_d);
      phase_start_d = (state_d != state_q);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_OFF;
         cnt_q         <= CNT_ZERO;
         code_q        <= CODE_DARK;
         phase_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         code_q        <= code_d;
         phase_start_q <= phase_start_d;
      end
   end

   assign code        = code_q;
   assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed self-checking bench for traffic_ctrl: default timing instance plus
// an all-ones timing instance for the single-tick phase edge case.
module tb_traffic_ctrl;

   logic       clk = 1'b0;
   logic       rst, tick, run, fault;
   logic [1:0] code;
   logic       phase_start;

   logic       rst1, tick1, run1, fault1;
   logic [1:0] code1;
   logic       phase_start1;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   traffic_ctrl dut (
      .clk(clk), .rst(rst), .tick(tick), .run(run), .fault(fault),
      .code(code), .phase_start(phase_start)
   );

   traffic_ctrl #(.RED_T(1), .GREEN_T(1), .YELLOW_T(1), .CW(4)) dut1 (
      .clk(clk), .rst(rst1), .tick(tick1), .run(run1), .fault(fault1),
      .code(code1), .phase_start(phase_start1)
   );

   task automatic chk(input string tag, input logic [1:0] exp_code, input logic exp_ps);
      total++;
      assert (code === exp_code) passed++;
      else $error("FAIL %s code: got %b expected %b", tag, code, exp_code);
      total++;
      assert (phase_start === exp_ps) passed++;
      else $error("FAIL %s phase_start: got %b expected %b", tag, phase_start, exp_ps);
   endtask

   task automatic chk1(input string tag, input logic [1:0] exp_code, input logic exp_ps);
      total++;
      assert (code1 === exp_code) passed++;
      else $error("FAIL %s code: got %b expected %b", tag, code1, exp_code);
      total++;
      assert (phase_start1 === exp_ps) passed++;
      else $error("FAIL %s phase_start: got %b expected %b", tag, phase_start1, exp_ps);
   endtask

   // Drive tick for one edge, then sample 1 time unit after that edge.
   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   // n ticks spaced 4 clks apart; phase changes to nxt on the n-th tick.
   task automatic ticks(input string tag, input int n, input logic [1:0] cur, input logic [1:0] nxt);
      for (int i = 1; i <= n; i++) begin
         cyc(1'b1);
         if (i < n) chk(tag, cur, 1'b0);
         else       chk(tag, nxt, 1'b1);
         for (int j = 0; j < 3; j++) begin
            cyc(1'b0);
            chk(tag, (i < n) ? cur : nxt, 1'b0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; run = 1'b0; fault = 1'b0;
      rst1 = 1'b1; tick1 = 1'b1; run1 = 1'b1; fault1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 2'b11, 1'b0);

      // Idle with run low: ticks are ignored.
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc(i[0]);
         chk("idle", 2'b11, 1'b0);
      end

      // Full cycle.
      run = 1'b1;
      cyc(1'b0);
      chk("enter_red", 2'b00, 1'b1);
      cyc(1'b0);
      chk("red_hold", 2'b00, 1'b0);
      ticks("red", 6, 2'b00, 2'b10);
      ticks("green", 8, 2'b10, 2'b01);
      ticks("yellow", 2, 2'b01, 2'b00);
      ticks("red2", 6, 2'b00, 2'b10);

      // Fault mid-green at counter 3.
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1);
         chk("green_cnt", 2'b10, 1'b0);
      end
      fault = 1'b1;
      cyc(1'b0);
      chk("blk_enter", 2'b01, 1'b1);
      cyc(1'b0);
      chk("blk_hold", 2'b01, 1'b0);
      cyc(1'b1);
      chk("blk_off", 2'b11, 1'b1);
      cyc(1'b0);
      chk("blk_off_hold", 2'b11, 1'b0);
      cyc(1'b1);
      chk("blk_on", 2'b01, 1'b1);
      fault = 1'b0;
      cyc(1'b0);
      chk("blk_exit_red", 2'b00, 1'b1);
      ticks("red_after_blk", 6, 2'b00, 2'b10);

      // Terminal yellow tick with run dropping on the same edge.
      ticks("green2", 8, 2'b10, 2'b01);
      cyc(1'b1);
      chk("yellow_cnt", 2'b01, 1'b0);
      run = 1'b0;
      cyc(1'b1);
      chk("term_tick_run0", 2'b11, 1'b1);

      // Tick and fault together in red at counter 5.
      run = 1'b1;
      cyc(1'b0);
      chk("restart_red", 2'b00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1);
         chk("red_cnt", 2'b00, 1'b0);
      end
      fault = 1'b1;
      cyc(1'b1);
      chk("tick_and_fault", 2'b01, 1'b1);
      fault = 1'b0; run = 1'b0;
      cyc(1'b0);
      chk("blk_exit_off", 2'b11, 1'b1);

      // Asynchronous reset mid-green.
      run = 1'b1;
      cyc(1'b0);
      chk("red3", 2'b00, 1'b1);
      ticks("red3", 6, 2'b00, 2'b10);
      cyc(1'b1);
      chk("green3", 2'b10, 1'b0);
      #2 rst = 1'b1;
      #1 chk("async_rst", 2'b11, 1'b0);
      @(posedge clk);
      #1;
      run = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1);
         chk("idle_after_rst", 2'b11, 1'b0);
      end

      // Single-tick phases, tick every clk.
      rst1 = 1'b0;
      @(posedge clk); #1;
      chk1("t1_red", 2'b00, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk1("t1_green", 2'b10, 1'b1);
         @(posedge clk); #1;
         chk1("t1_yellow", 2'b01, 1'b1);
         @(posedge clk); #1;
         chk1("t1_red", 2'b00, 1'b1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
